// File: rtl/sd_data_xfer_ctrl.sv
// ----------------------------------------------------------------------------
// sd_data_xfer_ctrl
//   Sequences a multi-block SD data transfer. A start pulse latches the
//   direction, block count and per-block timeout. Each block is kicked off
//   with blk_start_o and then watched for completion, CRC status, FIFO
//   under/overrun, timeout and abort. The block collects the outcome in
//   sticky interrupt status bits.
//
// Ports
//   sd_clk, rst_n        clock, asynchronous active-low reset
//   start_rx_i/_tx_i     start a read / write transfer (read wins if both)
//   blkcnt_i             number of blocks minus 1, sampled at start
//   timeout_i            per-block timeout in cycles (0 = disabled)
//   blk_done_i, crc_ok_i block finished, with its CRC status
//   tx_fifo_empty_i      TX underrun (write transfers only)
//   rx_fifo_full_i       RX overrun (read transfers only)
//   abort_i              level: stop the transfer
//   int_status_rst_i     clear int_status_o
//   blk_start_o          one-cycle pulse that starts one block
//   dir_o                1 = read, 0 = write
//   busy_o               high while not idle
//   blk_left_o           blocks remaining minus 1
//   xfer_end_o           one-cycle pulse when the transfer terminates
//   int_status_o         sticky {FIFOE, CCRC, CTE, EI, CC}
// ----------------------------------------------------------------------------
module sd_data_xfer_ctrl (
    input  logic        sd_clk,
    input  logic        rst_n,
    input  logic        start_rx_i,
    input  logic        start_tx_i,
    input  logic [15:0] blkcnt_i,
    input  logic [23:0] timeout_i,
    input  logic        blk_done_i,
    input  logic        crc_ok_i,
    input  logic        tx_fifo_empty_i,
    input  logic        rx_fifo_full_i,
    input  logic        abort_i,
    input  logic        int_status_rst_i,
    output logic        blk_start_o,
    output logic        dir_o,
    output logic        busy_o,
    output logic [15:0] blk_left_o,
    output logic        xfer_end_o,
    output logic [4:0]  int_status_o
);

    typedef enum logic [2:0] {IDLE, START, WAIT, CHECK, DONE} state_t;

    localparam logic [4:0] ST_CC    = 5'b00001;
    localparam logic [4:0] ST_EI    = 5'b00010;
    localparam logic [4:0] ST_CTE   = 5'b00100;
    localparam logic [4:0] ST_CCRC  = 5'b01000;
    localparam logic [4:0] ST_FIFOE = 5'b10000;

    state_t      state, next_state;
    logic [23:0] timeout_lat;
    logic [23:0] tmo_cnt;
    logic        crc_ok_q;
    logic [4:0]  set_bits;
    logic        dec_blk;
    logic        fifo_err;

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        set_bits   = 5'b00000;
        dec_blk    = 1'b0;
        fifo_err   = dir_o ? rx_fifo_full_i : tx_fifo_empty_i;

        case (state)
            IDLE: begin
                if (start_rx_i || start_tx_i) next_state = START;
            end
            START: begin
                if (abort_i) begin
                    set_bits   = ST_EI;
                    next_state = DONE;
                end else begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (abort_i) begin
                    set_bits   = ST_EI;
                    next_state = DONE;
                end else if (blk_done_i) begin
                    next_state = CHECK;
                end else if (fifo_err) begin
                    set_bits   = ST_FIFOE | ST_EI;
                    next_state = DONE;
                end else if (tmo_cnt == 24'd1 && timeout_lat != 24'd0) begin
                    // Counter was loaded with the timeout on entry, so it
                    // reads 1 during the last allowed WAIT cycle.
                    set_bits   = ST_CTE | ST_EI;
                    next_state = DONE;
                end
            end
            CHECK: begin
                if (abort_i) begin
                    set_bits   = ST_EI;
                    next_state = DONE;
                end else if (!crc_ok_q) begin
                    set_bits   = ST_CCRC | ST_EI;
                    next_state = DONE;
                end else if (blk_left_o == 16'd0) begin
                    set_bits   = ST_CC;
                    next_state = DONE;
                end else begin
                    dec_blk    = 1'b1;
                    next_state = START;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge sd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            blk_start_o  <= 1'b0;
            dir_o        <= 1'b0;
            busy_o       <= 1'b0;
            xfer_end_o   <= 1'b0;
            blk_left_o   <= 16'd0;
            int_status_o <= 5'b00000;
            tmo_cnt      <= 24'd0;
            timeout_lat  <= 24'd0;
            crc_ok_q     <= 1'b0;
        end else begin
            state       <= next_state;
            busy_o      <= (next_state != IDLE);
            xfer_end_o  <= (next_state == DONE);
            // Registered: the pulse appears during the first WAIT cycle, so
            // it lands 2 edges after a start and 3 edges after blk_done_i.
            blk_start_o <= (state == START) && (next_state == WAIT);
            // A clear and a set in the same cycle leave the new bits set.
            int_status_o <= (int_status_rst_i ? 5'b00000 : int_status_o) | set_bits;

            case (state)
                IDLE: begin
                    if (start_rx_i || start_tx_i) begin
                        dir_o       <= start_rx_i;
                        blk_left_o  <= blkcnt_i;
                        timeout_lat <= timeout_i;
                    end
                end
                START: tmo_cnt <= timeout_lat;
                WAIT: begin
                    if (tmo_cnt != 24'd0) tmo_cnt <= tmo_cnt - 24'd1;
                    if (blk_done_i) crc_ok_q <= crc_ok_i;
                end
                CHECK: begin
                    if (dec_blk) blk_left_o <= blk_left_o - 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_data_xfer_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sd_data_xfer_ctrl
//   Directed bench for sd_data_xfer_ctrl. The stimulus thread queues the
//   expected blk_left_o at every blk_start_o pulse and the expected outcome
//   of every transfer; a monitor on the falling clock edge pops and compares
//   whenever the DUT pulses blk_start_o or xfer_end_o. Cycle-exact latency
//   and reset behaviour are checked inline by the stimulus thread.
// ----------------------------------------------------------------------------
module tb_sd_data_xfer_ctrl;

    logic        sd_clk = 1'b0;
    logic        rst_n  = 1'b0;
    logic        start_rx_i = 1'b0, start_tx_i = 1'b0;
    logic [15:0] blkcnt_i = 16'd0;
    logic [23:0] timeout_i = 24'd0;
    logic        blk_done_i = 1'b0, crc_ok_i = 1'b0;
    logic        tx_fifo_empty_i = 1'b0, rx_fifo_full_i = 1'b0;
    logic        abort_i = 1'b0, int_status_rst_i = 1'b0;
    logic        blk_start_o, dir_o, busy_o, xfer_end_o;
    logic [15:0] blk_left_o;
    logic [4:0]  int_status_o;

    sd_data_xfer_ctrl dut (
        .sd_clk           (sd_clk),
        .rst_n            (rst_n),
        .start_rx_i       (start_rx_i),
        .start_tx_i       (start_tx_i),
        .blkcnt_i         (blkcnt_i),
        .timeout_i        (timeout_i),
        .blk_done_i       (blk_done_i),
        .crc_ok_i         (crc_ok_i),
        .tx_fifo_empty_i  (tx_fifo_empty_i),
        .rx_fifo_full_i   (rx_fifo_full_i),
        .abort_i          (abort_i),
        .int_status_rst_i (int_status_rst_i),
        .blk_start_o      (blk_start_o),
        .dir_o            (dir_o),
        .busy_o           (busy_o),
        .blk_left_o       (blk_left_o),
        .xfer_end_o       (xfer_end_o),
        .int_status_o     (int_status_o)
    );

    always #5 sd_clk = ~sd_clk;

    typedef struct {
        logic       dir;
        logic [4:0] status;
        int         nblk;
    } xfer_t;

    xfer_t       xq[$];
    logic [15:0] blk_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          nblk        = 0;
    int          xfer_seen   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag_unexpected(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: DUT pulsed with nothing queued at %0t", name, $time);
    endtask

    // Monitor: decoupled from the stimulus, samples on the falling edge.
    always @(negedge sd_clk) begin
        if (!rst_n) begin
            nblk = 0;
        end else begin
            if (blk_start_o) begin
                nblk++;
                if (blk_q.size() == 0) flag_unexpected("blk_start");
                else check("blk_left_at_blk_start", 32'(blk_left_o), 32'(blk_q.pop_front()));
            end
            if (xfer_end_o) begin
                xfer_t t;
                xfer_seen++;
                if (xq.size() == 0) begin
                    flag_unexpected("xfer_end");
                end else begin
                    t = xq.pop_front();
                    check("xfer_dir", 32'(dir_o), 32'(t.dir));
                    check("xfer_status", 32'(int_status_o), 32'(t.status));
                    check("xfer_blk_starts", 32'(nblk), 32'(t.nblk));
                    check("xfer_busy_in_done", 32'(busy_o), 32'd1);
                end
                nblk = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance to just after the n-th next rising edge.
    task automatic tick(input int n = 1);
        repeat (n) @(posedge sd_clk);
        #1;
    endtask

    // Pulse a start and check the first cycle in START.
    task automatic start_xfer(input logic rx, input logic tx,
                              input logic [15:0] cnt, input logic [23:0] tmo);
        start_rx_i = rx; start_tx_i = tx; blkcnt_i = cnt; timeout_i = tmo;
        tick();
        start_rx_i = 1'b0; start_tx_i = 1'b0;
        blkcnt_i = 16'($urandom); timeout_i = 24'($urandom);
        check("busy_after_start", 32'(busy_o), 32'd1);
        check("blk_start_not_yet", 32'(blk_start_o), 32'd0);
    endtask

    task automatic expect_first_blk_start();
        tick();
        check("blk_start_latency2", 32'(blk_start_o), 32'd1);
    endtask

    // Finish a block; if more blocks follow, check the 3-edge restart.
    task automatic finish_blk(input logic crc, input logic more);
        blk_done_i = 1'b1; crc_ok_i = crc;
        tick();
        blk_done_i = 1'b0; crc_ok_i = 1'b0;
        if (more) begin
            tick();
            check("blk_start_early", 32'(blk_start_o), 32'd0);
            tick();
            check("blk_start_latency3", 32'(blk_start_o), 32'd1);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy_o && n < budget) begin
            tick();
            n++;
        end
        check("idle_within_budget", 32'(busy_o), 32'd0);
    endtask

    task automatic clr_status();
        int_status_rst_i = 1'b1;
        tick();
        int_status_rst_i = 1'b0;
        check("status_cleared", 32'(int_status_o), 32'd0);
    endtask

    initial begin
        // Reset state
        tick(2);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_blk_start", 32'(blk_start_o), 32'd0);
        check("rst_xfer_end", 32'(xfer_end_o), 32'd0);
        check("rst_blk_left", 32'(blk_left_o), 32'd0);
        check("rst_status", 32'(int_status_o), 32'd0);
        rst_n = 1'b1;
        tick(2);
        check("idle_after_rst", 32'(busy_o), 32'd0);

        // Read, 3 blocks, all CRC good; a start while busy is ignored
        blk_q.push_back(16'd2); blk_q.push_back(16'd1); blk_q.push_back(16'd0);
        xq.push_back('{1'b1, 5'b00001, 3});
        start_xfer(1'b1, 1'b0, 16'd2, 24'd100);
        expect_first_blk_start();
        check("read_dir", 32'(dir_o), 32'd1);
        start_tx_i = 1'b1; blkcnt_i = 16'd7;
        tick();
        start_tx_i = 1'b0;
        check("busy_start_ignored_dir", 32'(dir_o), 32'd1);
        check("busy_start_ignored_cnt", 32'(blk_left_o), 32'd2);
        tick(2);
        finish_blk(1'b1, 1'b1);
        tick(3);
        finish_blk(1'b1, 1'b1);
        tick();
        finish_blk(1'b1, 1'b0);
        wait_idle(5);
        check("cc_sticky", 32'(int_status_o), 32'd1);
        clr_status();

        // Write, 1 block, timeout 10, no blk_done
        blk_q.push_back(16'd0);
        xq.push_back('{1'b0, 5'b00110, 1});
        start_xfer(1'b0, 1'b1, 16'd0, 24'd10);
        expect_first_blk_start();
        tick(9);
        check("tmo_wait9_busy", 32'(busy_o), 32'd1);
        check("tmo_wait9_status", 32'(int_status_o), 32'd0);
        tick();
        check("tmo_wait10_status", 32'(int_status_o), 32'b00110);
        check("tmo_xfer_end", 32'(xfer_end_o), 32'd1);
        tick();
        check("tmo_busy_drop", 32'(busy_o), 32'd0);
        clr_status();

        // Write, 2 blocks, timeout disabled, second block CRC bad
        blk_q.push_back(16'd1); blk_q.push_back(16'd0);
        xq.push_back('{1'b0, 5'b01010, 2});
        start_xfer(1'b0, 1'b1, 16'd1, 24'd0);
        expect_first_blk_start();
        tick(30);
        check("tmo_disabled_busy", 32'(busy_o), 32'd1);
        finish_blk(1'b1, 1'b1);
        tick(2);
        finish_blk(1'b0, 1'b0);
        wait_idle(5);
        clr_status();

        // Both starts together: read wins; TX empty ignored on read; RX full
        blk_q.push_back(16'd3);
        xq.push_back('{1'b1, 5'b10010, 1});
        start_xfer(1'b1, 1'b1, 16'd3, 24'd0);
        check("both_start_dir", 32'(dir_o), 32'd1);
        expect_first_blk_start();
        tx_fifo_empty_i = 1'b1;
        tick(3);
        check("tx_empty_ignored_on_read", 32'(busy_o), 32'd1);
        start_tx_i = 1'b1; blkcnt_i = 16'd9;
        tick();
        start_tx_i = 1'b0;
        check("busy_start_ignored_dir2", 32'(dir_o), 32'd1);
        rx_fifo_full_i = 1'b1;
        tick();
        rx_fifo_full_i = 1'b0; tx_fifo_empty_i = 1'b0;
        check("fifo_err_status", 32'(int_status_o), 32'b10010);
        wait_idle(5);
        clr_status();

        // Abort in WAIT beats a coincident good blk_done
        blk_q.push_back(16'd0);
        xq.push_back('{1'b1, 5'b00010, 1});
        start_xfer(1'b1, 1'b0, 16'd0, 24'd50);
        expect_first_blk_start();
        tick(2);
        abort_i = 1'b1; blk_done_i = 1'b1; crc_ok_i = 1'b1;
        tick();
        abort_i = 1'b0; blk_done_i = 1'b0; crc_ok_i = 1'b0;
        check("abort_status", 32'(int_status_o), 32'b00010);
        wait_idle(5);

        // Status clear coinciding with CC set: EI cleared, CC kept
        blk_q.push_back(16'd0);
        xq.push_back('{1'b1, 5'b00001, 1});
        start_xfer(1'b1, 1'b0, 16'd0, 24'd0);
        expect_first_blk_start();
        tick();
        blk_done_i = 1'b1; crc_ok_i = 1'b1;
        tick();
        blk_done_i = 1'b0; crc_ok_i = 1'b0; int_status_rst_i = 1'b1;
        tick();
        int_status_rst_i = 1'b0;
        check("set_wins_over_clear", 32'(int_status_o), 32'b00001);
        wait_idle(5);

        // Reset mid-WAIT: outputs clear at once, no xfer_end
        blk_q.push_back(16'd2);
        start_xfer(1'b1, 1'b0, 16'd2, 24'd0);
        expect_first_blk_start();
        tick(2);
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", 32'(busy_o), 32'd0);
        check("async_rst_dir", 32'(dir_o), 32'd0);
        check("async_rst_blk_left", 32'(blk_left_o), 32'd0);
        check("async_rst_status", 32'(int_status_o), 32'd0);
        check("async_rst_xfer_end", 32'(xfer_end_o), 32'd0);
        tick(3);

        // Start accepted on the first edge after reset; abort in START
        rst_n = 1'b1;
        xq.push_back('{1'b1, 5'b00010, 0});
        start_xfer(1'b1, 1'b0, 16'd0, 24'd0);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("abort_start_no_blk", 32'(blk_start_o), 32'd0);
        check("abort_start_xfer_end", 32'(xfer_end_o), 32'd1);
        wait_idle(5);

        tick(5);
        check("xfer_end_count", 32'(xfer_seen), 32'd7);
        check("xfer_queue_drained", 32'(xq.size()), 32'd0);
        check("blk_queue_drained", 32'(blk_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
